// File: rtl/rhd_spi_responder.sv
// rhd_spi_responder -- chip-side model of the RHD2000 SPI link.
//
// Oversamples CS/SCLK/MOSI on aclk, decodes 16-bit RHD commands, keeps the
// 22-entry register file and the read-only ID ROM, and returns each result on
// MISO two frames later (RHD command pipeline).
//
// Ports
//   aclk        in   system clock, >= 4x SCLK
//   aresetn     in   asynchronous active-low reset
//   CS          in   SPI chip select, active low (async)
//   SCLK        in   SPI clock, idle low (async)
//   MOSI        in   SPI data from master, MSB first (async)
//   MISO        out  SPI data to master, MSB first
//   miso_delay  in   extra MISO delay in aclk cycles (delay build only)
//   frame_done  out  1-cycle pulse, valid 16-bit frame decoded
//   frame_err   out  1-cycle pulse, CS rose with bit count != 16
//   last_cmd    out  last valid command word
//   conv_cnt    out  valid CONVERT count, wraps 1023 -> 0
//
// Build option
//   RHD_MISO_DELAY_EN  route MISO through a MAX_DELAY-deep aclk delay line,
//                      tap = min(miso_delay, MAX_DELAY).

module rhd_spi_responder #(
    parameter int NUM_CH    = 32,
    parameter int CHIP_ID   = 1,
    parameter int MAX_DELAY = 15
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        CS,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [3:0]  miso_delay,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] last_cmd,
    output logic [9:0]  conv_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DECODE
    } state_t;

    localparam logic [6:0] NUM_CH_L = 7'((NUM_CH > 64) ? 64 : NUM_CH);

    // [0],[1] form the synchronizer, [2] holds the previous synced value.
    // CS sync resets low so a CS held low across reset release is not seen
    // as a fall: the next frame starts only at a genuine CS fall.
    logic [2:0]  cs_q, sclk_q;
    logic [1:0]  mosi_q;
    logic        cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_s;

    state_t      state_q, state_d;
    logic [15:0] tx_sr_q, tx_sr_d;
    logic [15:0] rx_sr_q, rx_sr_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        miso_q, miso_d;
    logic [15:0] pipe0_q, pipe0_d;
    logic [15:0] pipe1_q, pipe1_d;
    logic [7:0]  regs_q [0:21];
    logic [7:0]  regs_d [0:21];
    logic [15:0] last_cmd_q, last_cmd_d;
    logic [9:0]  conv_cnt_q, conv_cnt_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_err_q, frame_err_d;

    // command decode of rx_sr
    logic [5:0]  addr;
    logic [7:0]  rd_val;
    logic [15:0] result;
    logic        conv_inc, conv_clr, wr_en;

    assign cs_fall   = cs_q[2] & ~cs_q[1];
    assign cs_rise   = ~cs_q[2] & cs_q[1];
    assign sclk_rise = ~sclk_q[2] & sclk_q[1];
    assign sclk_fall = sclk_q[2] & ~sclk_q[1];
    assign mosi_s    = mosi_q[1];
    assign addr      = rx_sr_q[13:8];

    always_comb begin
        rd_val = '0;
        if (addr <= 6'd21) begin
            rd_val = regs_q[addr[4:0]];
        end else begin
            case (addr)
                6'd40:   rd_val = 8'h49;
                6'd41:   rd_val = 8'h4E;
                6'd42:   rd_val = 8'h54;
                6'd43:   rd_val = 8'h41;
                6'd44:   rd_val = 8'h4E;
                6'd60:   rd_val = 8'h01;
                6'd61:   rd_val = 8'h01;
                6'd62:   rd_val = 8'(NUM_CH);
                6'd63:   rd_val = 8'(CHIP_ID);
                default: rd_val = '0;
            endcase
        end
    end

    always_comb begin
        result   = '0;
        conv_inc = 1'b0;
        conv_clr = 1'b0;
        wr_en    = 1'b0;
        case (rx_sr_q[15:14])
            2'b00: begin
                conv_inc = 1'b1;
                if ({1'b0, addr} < NUM_CH_L) result = {addr, conv_cnt_q};
            end
            2'b01: begin
                // CALIBRATE and unknown 01 words return zero with no side effect
                if (rx_sr_q == 16'h6A00) conv_clr = 1'b1;
            end
            2'b10: begin
                result = {8'hFF, rx_sr_q[7:0]};
                wr_en  = (addr <= 6'd21);
            end
            default: begin
                result = {8'h00, rd_val};
            end
        endcase
    end

    always_comb begin
        state_d      = state_q;
        tx_sr_d      = tx_sr_q;
        rx_sr_d      = rx_sr_q;
        bit_cnt_d    = bit_cnt_q;
        miso_d       = miso_q;
        pipe0_d      = pipe0_q;
        pipe1_d      = pipe1_q;
        regs_d       = regs_q;
        last_cmd_d   = last_cmd_q;
        conv_cnt_d   = conv_cnt_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_SHIFT;
                    tx_sr_d   = pipe1_q;
                    bit_cnt_d = '0;
                    miso_d    = pipe1_q[15];
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    if (bit_cnt_q == 5'd16) begin
                        state_d = ST_DECODE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else if (sclk_rise) begin
                    rx_sr_d = {rx_sr_q[14:0], mosi_s};
                    if (bit_cnt_q != 5'd17) bit_cnt_d = bit_cnt_q + 5'd1;
                end else if (sclk_fall) begin
                    tx_sr_d = {tx_sr_q[14:0], 1'b0};
                    miso_d  = tx_sr_q[14];
                end
            end
            ST_DECODE: begin
                pipe1_d      = pipe0_q;
                pipe0_d      = result;
                last_cmd_d   = rx_sr_q;
                frame_done_d = 1'b1;
                if (wr_en) regs_d[addr[4:0]] = rx_sr_q[7:0];
                if (conv_clr) begin
                    conv_cnt_d = '0;
                end else if (conv_inc) begin
                    conv_cnt_d = conv_cnt_q + 10'd1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cs_q         <= '0;
            sclk_q       <= '0;
            mosi_q       <= '0;
            state_q      <= ST_IDLE;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            bit_cnt_q    <= '0;
            miso_q       <= 1'b0;
            pipe0_q      <= '0;
            pipe1_q      <= '0;
            for (int unsigned i = 0; i < 22; i++) regs_q[i] <= '0;
            last_cmd_q   <= '0;
            conv_cnt_q   <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            cs_q         <= {cs_q[1:0], CS};
            sclk_q       <= {sclk_q[1:0], SCLK};
            mosi_q       <= {mosi_q[0], MOSI};
            state_q      <= state_d;
            tx_sr_q      <= tx_sr_d;
            rx_sr_q      <= rx_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            miso_q       <= miso_d;
            pipe0_q      <= pipe0_d;
            pipe1_q      <= pipe1_d;
            regs_q       <= regs_d;
            last_cmd_q   <= last_cmd_d;
            conv_cnt_q   <= conv_cnt_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign last_cmd   = last_cmd_q;
    assign conv_cnt   = conv_cnt_q;

`ifdef RHD_MISO_DELAY_EN
    // dly_q[k] is miso_q delayed by k+1 aclk cycles
    logic [MAX_DELAY-1:0] dly_q;
    logic [3:0]           tap;

    always_comb begin
        tap = miso_delay;
        if (int'(miso_delay) > MAX_DELAY) tap = 4'(MAX_DELAY);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            dly_q <= '0;
        end else begin
            dly_q <= {dly_q[MAX_DELAY-2:0], miso_q};
        end
    end

    assign MISO = (tap == 4'd0) ? miso_q : dly_q[tap - 4'd1];
`else
    logic unused_delay;
    assign unused_delay = ^{miso_delay, 4'(MAX_DELAY)};
    assign MISO         = miso_q;
`endif

endmodule

// File: tb/tb_rhd_spi_responder.sv
// Bench for rhd_spi_responder: directed vector table, hand-written corner
// sequences (short frame, mid-frame reset, idle SCLK) and randomized frames
// checked against a command-level reference model.

module tb_rhd_spi_responder;

    localparam int NUM_CH  = 32;
    localparam int CHIP_ID = 1;
    localparam int HALF    = 80;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        CS = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic [3:0]  miso_delay = '0;
    logic        MISO;
    logic        frame_done, frame_err;
    logic [15:0] last_cmd;
    logic [9:0]  conv_cnt;

    rhd_spi_responder #(
        .NUM_CH    (NUM_CH),
        .CHIP_ID   (CHIP_ID),
        .MAX_DELAY (15)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .CS         (CS),
        .SCLK       (SCLK),
        .MOSI       (MOSI),
        .MISO       (MISO),
        .miso_delay (miso_delay),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .last_cmd   (last_cmd),
        .conv_cnt   (conv_cnt)
    );

    always #5 aclk = ~aclk;

    int nvec = 0;
    int nerr = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    always @(posedge aclk) begin
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (command level) ----------------
    logic [7:0]  m_regs [0:21];
    int          m_cnt;
    logic [15:0] m_pipe [$];

    function automatic void m_reset();
        foreach (m_regs[i]) m_regs[i] = 8'h00;
        m_cnt = 0;
        m_pipe = {};
        m_pipe.push_back(16'h0000);
        m_pipe.push_back(16'h0000);
    endfunction

    function automatic logic [7:0] m_read(int r);
        string id;
        id = "INTAN";
        if (r <= 21) return m_regs[r];
        if (r >= 40 && r <= 44) return id[r-40];
        if (r == 60 || r == 61) return 8'd1;
        if (r == 62) return 8'(NUM_CH);
        if (r == 63) return 8'(CHIP_ID);
        return 8'h00;
    endfunction

    function automatic logic [15:0] m_exec(logic [15:0] w);
        int c;
        logic [15:0] res;
        c = int'(w[13:8]);
        res = 16'h0000;
        case (w[15:14])
            2'b00: begin
                if (c < NUM_CH) res = 16'(c * 1024 + m_cnt);
                m_cnt = (m_cnt + 1) % 1024;
            end
            2'b01: if (w == 16'h6A00) m_cnt = 0;
            2'b10: begin
                if (c <= 21) m_regs[c] = w[7:0];
                res = 16'hFF00 | {8'h00, w[7:0]};
            end
            default: res = {8'h00, m_read(c)};
        endcase
        return res;
    endfunction

    // ---------------- SPI master ----------------
    task automatic set_delay();
`ifdef RHD_MISO_DELAY_EN
        miso_delay = 4'd4;
`else
        miso_delay = 4'($urandom);
`endif
    endtask

    task automatic spi_xfer(input logic [15:0] w, input int nbits, input int rst_after,
                            output logic [31:0] rx);
        rx = '0;
        set_delay();
        CS = 1'b0;
        #100;
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 16) ? w[15-i] : 1'b0;
            #HALF;
            rx = {rx[30:0], MISO};
            SCLK = 1'b1;
            #HALF;
            SCLK = 1'b0;
            if (i + 1 == rst_after) begin
                aresetn = 1'b0;
                #20;
                chk("miso_in_reset", 32'(MISO), 32'h0);
                chk("last_cmd_in_reset", 32'(last_cmd), 32'h0);
                #20;
                aresetn = 1'b1;
            end
        end
        #HALF;
        CS = 1'b1;
        #100;
    endtask

    task automatic do_frame(input logic [15:0] w, output logic [15:0] got);
        logic [31:0] rx;
        logic [15:0] exp;
        int d0, e0;
        exp = m_pipe[0];
        d0 = done_cnt;
        e0 = err_cnt;
        spi_xfer(w, 16, 0, rx);
        got = rx[15:0];
        void'(m_pipe.pop_front());
        m_pipe.push_back(m_exec(w));
        chk("miso_word", 32'(rx[15:0]), 32'(exp));
        chk("last_cmd", 32'(last_cmd), 32'(w));
        chk("conv_cnt", 32'(conv_cnt), 32'(m_cnt));
        chk("frame_done_pulses", 32'(done_cnt - d0), 32'd1);
        chk("frame_err_quiet", 32'(err_cnt - e0), 32'd0);
    endtask

    task automatic do_err_frame(input logic [15:0] w, input int nbits);
        logic [31:0] rx, exp;
        logic [15:0] lc;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        lc = last_cmd;
        if (nbits <= 16) exp = {16'h0, m_pipe[0]} >> (16 - nbits);
        else             exp = {16'h0, m_pipe[0]} << (nbits - 16);
        spi_xfer(w, nbits, 0, rx);
        chk("short_frame_err", 32'(err_cnt - e0), 32'd1);
        chk("short_frame_no_done", 32'(done_cnt - d0), 32'd0);
        chk("short_frame_miso", rx, exp);
        chk("short_frame_last_cmd", 32'(last_cmd), 32'(lc));
        chk("short_frame_conv_cnt", 32'(conv_cnt), 32'(m_cnt));
    endtask

    task automatic idle_sclk();
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        MOSI = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #HALF; SCLK = 1'b1; #HALF; SCLK = 1'b0;
        end
        #100;
        chk("idle_sclk_no_done", 32'(done_cnt - d0), 32'd0);
        chk("idle_sclk_no_err", 32'(err_cnt - e0), 32'd0);
    endtask

    function automatic logic [15:0] rand_cmd();
        logic [15:0] w;
        int r;
        case ($urandom_range(0, 3))
            0: w = {2'b00, 6'($urandom_range(0, 63)), 8'($urandom)};
            1: begin
                case ($urandom_range(0, 2))
                    0: w = 16'h5500;
                    1: w = 16'h6A00;
                    default: w = {2'b01, 14'($urandom)};
                endcase
            end
            2: w = {2'b10, 6'($urandom_range(0, 23)), 8'($urandom)};
            default: begin
                r = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 23) : $urandom_range(0, 63);
                w = {2'b11, 6'(r), 8'h00};
            end
        endcase
        return w;
    endfunction

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] miso;
        logic [9:0]  cnt;
    } vec_t;

    vec_t tbl [22];

    initial begin
        logic [15:0] got;
        logic [31:0] rx;
        int d0, e0, k;

        tbl[0]  = '{16'h0000, 16'h0000, 10'd1};
        tbl[1]  = '{16'h0100, 16'h0000, 10'd2};
        tbl[2]  = '{16'h0200, 16'h0000, 10'd3};
        tbl[3]  = '{16'h0000, 16'h0401, 10'd4};
        tbl[4]  = '{16'h0000, 16'h0802, 10'd5};
        tbl[5]  = '{16'h85A3, 16'h0003, 10'd5};
        tbl[6]  = '{16'hC500, 16'h0004, 10'd5};
        tbl[7]  = '{16'hE800, 16'hFFA3, 10'd5};
        tbl[8]  = '{16'hE900, 16'h00A3, 10'd5};
        tbl[9]  = '{16'hEA00, 16'h0049, 10'd5};
        tbl[10] = '{16'hEB00, 16'h004E, 10'd5};
        tbl[11] = '{16'hEC00, 16'h0054, 10'd5};
        tbl[12] = '{16'hFE00, 16'h0041, 10'd5};
        tbl[13] = '{16'hFF00, 16'h004E, 10'd5};
        tbl[14] = '{16'h5500, 16'h0020, 10'd5};
        tbl[15] = '{16'h6A00, 16'h0001, 10'd0};
        tbl[16] = '{16'h2000, 16'h0000, 10'd1};
        tbl[17] = '{16'h3F00, 16'h0000, 10'd2};
        tbl[18] = '{16'h9611, 16'h0000, 10'd2};
        tbl[19] = '{16'hD600, 16'h0000, 10'd2};
        tbl[20] = '{16'hD600, 16'hFF11, 10'd2};
        tbl[21] = '{16'hD600, 16'h0000, 10'd2};

        #3;
        #20;
        chk("rst_miso", 32'(MISO), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_last_cmd", 32'(last_cmd), 32'h0);
        chk("rst_conv_cnt", 32'(conv_cnt), 32'h0);
        aresetn = 1'b1;
        #50;
        m_reset();

        // directed vector table
        foreach (tbl[i]) begin
            d0 = done_cnt;
            spi_xfer(tbl[i].cmd, 16, 0, rx);
            void'(m_pipe.pop_front());
            m_pipe.push_back(m_exec(tbl[i].cmd));
            chk("tbl_miso", 32'(rx[15:0]), 32'(tbl[i].miso));
            chk("tbl_last_cmd", 32'(last_cmd), 32'(tbl[i].cmd));
            chk("tbl_conv_cnt", 32'(conv_cnt), 32'(tbl[i].cnt));
            chk("tbl_frame_done", 32'(done_cnt - d0), 32'd1);
        end

        // SCLK with CS high, then short and over-long frames
        idle_sclk();
        do_frame(16'h8A5C, got);
        do_err_frame(16'h0000, 12);
        do_frame(16'hCA00, got);
        do_err_frame(16'hC000, 0);
        do_err_frame(16'h0100, 17);
        do_frame(16'h0300, got);
        do_frame(16'h0000, got);

        // reset in the middle of a WRITE: register must come back cleared
        do_frame(16'h8377, got);
        do_frame(16'hC300, got);
        do_frame(16'h0000, got);
        chk("r3_written", 32'(got), 32'h0000FF77);
        d0 = done_cnt;
        e0 = err_cnt;
        spi_xfer(16'h8355, 16, 8, rx);
        chk("rst_frame_no_done", 32'(done_cnt - d0), 32'd0);
        chk("rst_frame_no_err", 32'(err_cnt - e0), 32'd0);
        chk("rst_conv_cleared", 32'(conv_cnt), 32'd0);
        m_reset();
        do_frame(16'hC300, got);
        do_frame(16'hC300, got);
        do_frame(16'hC300, got);
        chk("r3_after_reset", 32'(got), 32'h0);

        // randomized frames against the model
        for (int n = 0; n < 50; n++) begin
            k = $urandom_range(0, 9);
            if (k == 0) begin
                case ($urandom_range(0, 2))
                    0: do_err_frame(rand_cmd(), $urandom_range(0, 15));
                    1: do_err_frame(rand_cmd(), $urandom_range(17, 18));
                    default: do_err_frame(rand_cmd(), $urandom_range(1, 15));
                endcase
            end else begin
                if (k == 1) idle_sclk();
                do_frame(rand_cmd(), got);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
